// File: rtl/hist_seq_ctrl.sv
// Frame histogram sequencer: clears the bin RAM, accumulates pixel bins with
// read-modify-write forwarding, then dumps every bin with a running cumulative sum.
module hist_seq_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic        f_val,
  input  logic        d_val,
  input  logic [7:0]  bin,
  output logic [7:0]  ram_rd_addr,
  input  logic [19:0] ram_rd_data,
  output logic        ram_we,
  output logic [7:0]  ram_wr_addr,
  output logic [19:0] ram_wr_data,
  output logic        dump_valid,
  output logic [7:0]  dump_addr,
  output logic [19:0] dump_count,
  output logic [19:0] dump_cum,
  output logic        frame_done,
  output logic        frame_dropped,
  output logic [2:0]  state
);

  localparam int unsigned AW = 8;
  localparam int unsigned DW = 20;
  localparam int unsigned CW = AW + 1;
  localparam logic [DW-1:0] CNT_MAX = {DW{1'b1}};

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLEAR = 3'd1,
    ST_ACCUM = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DUMP  = 3'd4
  } state_t;

  state_t        st, st_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          f_val_d;
  logic          rise;
  logic          accept;

  logic          p1_valid;
  logic [AW-1:0] p1_bin;
  logic          fwd_we;
  logic [AW-1:0] fwd_addr;
  logic [DW-1:0] fwd_data;
  logic [DW-1:0] base;
  logic [DW-1:0] inc;

  logic [DW-1:0] sum;
  logic [DW:0]   cum_wide;
  logic [DW-1:0] cum_sat;

  logic          we_nxt;
  logic [AW-1:0] wr_addr_nxt;
  logic          dv_nxt;
  logic [AW-1:0] da_nxt;
  logic          done_nxt;
  logic          drop_nxt;

  assign state = st;

  // Next state, read address and next values of the registered strobes
  always_comb begin
    st_nxt      = st;
    cnt_nxt     = cnt;
    rise        = f_val & ~f_val_d;
    accept      = 1'b0;
    ram_rd_addr = '0;
    we_nxt      = 1'b0;
    wr_addr_nxt = '0;
    dv_nxt      = 1'b0;
    da_nxt      = '0;
    done_nxt    = 1'b0;
    drop_nxt    = 1'b0;
    case (st)
      ST_CLEAR: begin
        drop_nxt = rise;
        if (cnt[AW]) begin
          st_nxt  = ST_IDLE;
          cnt_nxt = '0;
        end else begin
          we_nxt      = 1'b1;
          wr_addr_nxt = cnt[AW-1:0];
          cnt_nxt     = cnt + CW'(1);
        end
      end
      ST_IDLE: begin
        if (rise) begin
          st_nxt = ST_ACCUM;
          accept = d_val;
        end
      end
      ST_ACCUM: begin
        if (!f_val) st_nxt = ST_DRAIN;
        else        accept = d_val;
      end
      ST_DRAIN: begin
        drop_nxt = rise;
        st_nxt   = ST_DUMP;
        cnt_nxt  = '0;
      end
      ST_DUMP: begin
        drop_nxt = rise;
        if (cnt[AW]) begin
          st_nxt   = ST_IDLE;
          cnt_nxt  = '0;
          done_nxt = 1'b1;
        end else begin
          ram_rd_addr = cnt[AW-1:0];
          dv_nxt      = 1'b1;
          da_nxt      = cnt[AW-1:0];
          we_nxt      = 1'b1;
          wr_addr_nxt = cnt[AW-1:0];
          cnt_nxt     = cnt + CW'(1);
        end
      end
      default: st_nxt = ST_CLEAR;
    endcase
    if (accept) begin
      ram_rd_addr = bin;
      we_nxt      = 1'b1;
      wr_addr_nxt = bin;
    end
  end

  // Increment path: forward last written value when the RAM returns stale data
  always_comb begin
    base        = (fwd_we && (fwd_addr == p1_bin)) ? fwd_data : ram_rd_data;
    inc         = (base == CNT_MAX) ? base : base + DW'(1);
    ram_wr_data = p1_valid ? inc : '0;
    cum_wide    = {1'b0, sum} + {1'b0, ram_rd_data};
    cum_sat     = cum_wide[DW] ? CNT_MAX : cum_wide[DW-1:0];
    dump_count  = dump_valid ? ram_rd_data : '0;
    dump_cum    = dump_valid ? cum_sat : '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      st            <= ST_CLEAR;
      cnt           <= '0;
      f_val_d       <= 1'b0;
      p1_valid      <= 1'b0;
      p1_bin        <= '0;
      fwd_we        <= 1'b0;
      fwd_addr      <= '0;
      fwd_data      <= '0;
      sum           <= '0;
      ram_we        <= 1'b0;
      ram_wr_addr   <= '0;
      dump_valid    <= 1'b0;
      dump_addr     <= '0;
      frame_done    <= 1'b0;
      frame_dropped <= 1'b0;
    end else begin
      st            <= st_nxt;
      cnt           <= cnt_nxt;
      f_val_d       <= f_val;
      p1_valid      <= accept;
      p1_bin        <= bin;
      fwd_we        <= ram_we;
      fwd_addr      <= ram_wr_addr;
      fwd_data      <= ram_wr_data;
      ram_we        <= we_nxt;
      ram_wr_addr   <= wr_addr_nxt;
      dump_valid    <= dv_nxt;
      dump_addr     <= da_nxt;
      frame_done    <= done_nxt;
      frame_dropped <= drop_nxt;
      // Running sum restarts for every frame
      if (done_nxt)        sum <= '0;
      else if (dump_valid) sum <= cum_sat;
    end
  end

endmodule

// File: doc/hist_seq_ctrl.md
HIST_SEQ_CTRL -- requirements
Module: hist_seq_ctrl

Interface
REQ-001 SHALL have ports, clock and reset first:
- clk  in  1  sole clock; all logic on posedge.
- reset  in  1  synchronous, active-high.
- f_val  in  1  frame valid.
- d_val  in  1  pixel valid, qualified by f_val.
- bin  in  8  histogram bin of current pixel.
- ram_rd_addr  out  8  RAM read address.
- ram_rd_data  in  20  RAM read data, registered read, 1-cycle latency, old data on same-address collision.
- ram_we  out  1  RAM write enable.
- ram_wr_addr  out  8  RAM write address.
- ram_wr_data  out  20  RAM write data.
- dump_valid  out  1  dump beat strobe.
- dump_addr  out  8  bin index of dump beat.
- dump_count  out  20  bin count of dump beat.
- dump_cum  out  20  running cumulative count, inclusive.
- frame_done  out  1  one-cycle pulse after last dump beat.
- frame_dropped  out  1  one-cycle pulse on an ignored f_val rise.
- state  out  3  IDLE=0, CLEAR=1, ACCUM=2, DRAIN=3, DUMP=4.

Function
REQ-002 SHALL detect an f_val rise as f_val=1 while the registered f_val (f_val_d) is 0.
REQ-003 CLEAR SHALL assert ram_we with ram_wr_data=0, ram_wr_addr 0..255 on consecutive cycles (256 cycles total), then go to IDLE.
REQ-004 IDLE SHALL go to ACCUM on an f_val rise; otherwise it SHALL hold, including when f_val is already high.
REQ-005 A pixel SHALL be accepted when f_val & d_val and either state=ACCUM or (state=IDLE and f_val rise).
REQ-006 For an accepted pixel in cycle n, ram_rd_addr=bin in cycle n; stage P1 (bin registered, valid flag) SHALL hold it in cycle n+1.
REQ-007 In the cycle P1 is valid, ram_we=1, ram_wr_addr=P1.bin, ram_wr_data=base+1, saturating at 0xFFFFF.
REQ-008 base SHALL be the last written data if the previous cycle wrote the same address, else ram_rd_data; forwarding covers back-to-back same-bin pixels at full rate.
REQ-009 ACCUM SHALL go to DRAIN when f_val=0; DRAIN SHALL last 1 cycle, complete any pending P1 write, accept no pixels, then go to DUMP.
REQ-010 DUMP SHALL drive ram_rd_addr=k in dump cycle k=0..255.
REQ-011 In dump cycles k=1..256, dump_valid=1, dump_addr=k-1, dump_count=ram_rd_data, dump_cum=saturating 20-bit sum of dump_count over bins 0..k-1.
REQ-012 In the same cycles, ram_we=1, ram_wr_addr=k-1, ram_wr_data=0, so dump also clears the histogram.
REQ-013 frame_done SHALL pulse in the cycle after dump cycle 256; the block SHALL then enter IDLE with the running sum zeroed.
REQ-014 An f_val rise while state is CLEAR, DRAIN or DUMP SHALL pulse frame_dropped; that frame is not counted.
REQ-015 d_val with f_val=0, and d_val outside ACCUM/IDLE-rise, SHALL be ignored.
REQ-016 ram_we SHALL be 0 in any cycle not covered by REQ-003, REQ-007 or REQ-012.
REQ-017 Outputs other than ram_wr_data (combinational via the REQ-008 mux) SHALL be register-driven.
REQ-018 Unused-cycle values: ram_rd_addr=0; dump_addr, dump_count and dump_cum=0 when dump_valid=0.

Reset
REQ-019 On reset, state=CLEAR with clear address 0 next cycle.
REQ-020 On reset, P1, forwarding registers, running sum, f_val_d and every strobe SHALL be 0.
REQ-021 Reset mid-ACCUM or mid-DUMP SHALL abandon the frame and the partial dump, with no frame_done.
REQ-022 Reset held high SHALL keep state=CLEAR at address 0 with ram_we=0.

Verification
REQ-023 Reset release -> 256 zero writes to addr 0..255, state=IDLE at cycle 257.
REQ-024 Frame of 10 pixels all bin=5, d_val continuous -> dump beat addr 5: count=10; all other counts 0; final dump_cum=10.
REQ-025 Alternating bins 3,3,7,3 back-to-back -> bin 3 count=3, bin 7 count=1 (forwarding exercised).
REQ-026 Preload bin 9 = 0xFFFFE, then 3 pixels at bin 9 -> dump_count=0xFFFFF; dump_cum saturates at 0xFFFFF.
REQ-027 f_val rises during DUMP -> frame_dropped pulse; no ACCUM until f_val falls and rises again; the next frame's counts start from a cleared RAM.
REQ-028 Reset asserted at dump beat 100 -> no frame_done; CLEAR restarts at addr 0; the next frame dump matches its own pixels only.
